// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// FETCH_N       : default width of data bus, PC, address and instruction word
// FETCH_TIMEOUT : default mem_ack wait limit (used only when FETCH_TIMEOUT_EN is defined)
// fetch_state_e : sequencer state encoding
package fetch_pkg;

    localparam int unsigned FETCH_N       = 8;
    localparam int unsigned FETCH_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_MEM  = 3'd2,
        ST_HOLD = 3'd3,
        ST_JUMP = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/bus_drv.sv
// N-bit tri-state driver onto a shared bus.
// en  : drive din onto bus when 1, otherwise release bus (high-Z)
// din : value to drive
// bus : shared tri-state bus
module bus_drv #(
    parameter int unsigned N = 8
) (
    input  logic          en,
    input  logic [N-1:0]  din,
    inout  wire  [N-1:0]  bus
);

    assign bus = en ? din : {N{1'bz}};

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer sharing a tri-state data bus with the PC block.
// Reads the PC off the bus, runs a req/ack memory read, hands the word to the
// decoder over valid/ready and services jumps by driving the target onto the bus.
// Optional macro FETCH_TIMEOUT_EN: abort a memory read after TIMEOUT cycles
// without mem_ack and raise a sticky err flag.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   pc_valid/pc_inc/pc_load   PC control (drive bus / increment / load from bus)
//   data                      shared bus, driven here only while pc_load=1
//   mem_addr/mem_req          memory read address and request
//   mem_ack/mem_rdata         memory read completion and data
//   ir/ir_valid/ir_ready      fetched instruction handshake to the decoder
//   jmp_req/jmp_addr/jmp_ack  jump request (level), target, one-cycle acceptance
//   halt                      suppress new fetches
//   err                       memory timeout flag (0 unless FETCH_TIMEOUT_EN)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned N = FETCH_N
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = FETCH_TIMEOUT
`endif
) (
    input  logic          clk,
    input  logic          nrst,
    output logic          pc_valid,
    output logic          pc_inc,
    output logic          pc_load,
    inout  wire  [N-1:0]  data,
    output logic [N-1:0]  mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          jmp_req,
    input  logic [N-1:0]  jmp_addr,
    output logic          jmp_ack,
    input  logic          halt,
    output logic          err
);

    fetch_state_e  state;
    fetch_state_e  state_d;
    logic [N-1:0]  mem_addr_d;
    logic [N-1:0]  ir_d;
    logic          tmo_c;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    // Last permitted wait cycle passes without an ack
    assign tmo_c = (state == ST_MEM) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));

    // Wait counter is held at zero outside MEM, so it restarts on every MEM entry
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_MEM) ? wait_cnt + CW'(1) : '0;
            if (tmo_c) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign tmo_c = 1'b0;
    assign err   = 1'b0;
`endif

    // Next-state, pc_inc and datapath load decode
    always_comb begin
        state_d    = state;
        pc_inc     = 1'b0;
        mem_addr_d = mem_addr;
        ir_d       = ir;
        case (state)
            ST_IDLE: begin
                if (jmp_req) begin
                    state_d = ST_JUMP;
                end else if (!halt && !err) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_addr_d = data;
                state_d    = ST_MEM;
            end
            ST_MEM: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_inc  = 1'b1;
                    state_d = ST_HOLD;
                end else if (tmo_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A jump flushes the held instruction even if the decoder is ready
                if (jmp_req) begin
                    state_d = ST_JUMP;
                end else if (ir_ready) begin
                    state_d = halt ? ST_IDLE : ST_ADDR;
                end
            end
            ST_JUMP: begin
                state_d = (halt || err) ? ST_IDLE : ST_ADDR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Moore outputs registered from the next state so they line up with state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc_valid <= 1'b0;
            pc_load  <= 1'b0;
            jmp_ack  <= 1'b0;
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
            mem_addr <= '0;
            ir       <= '0;
        end else begin
            pc_valid <= (state_d == ST_ADDR);
            pc_load  <= (state_d == ST_JUMP);
            jmp_ack  <= (state_d == ST_JUMP);
            mem_req  <= (state_d == ST_MEM);
            ir_valid <= (state_d == ST_HOLD);
            mem_addr <= mem_addr_d;
            ir       <= ir_d;
        end
    end

    bus_drv #(
        .N (N)
    ) u_bus_drv (
        .en  (pc_load),
        .din (jmp_addr),
        .bus (data)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: plays the PC and the memory, checks every cycle
// against a transaction-level model of the fetch/jump protocol.
module tb_fetch_ctrl;

    localparam int unsigned N = 8;

    logic          clk;
    logic          nrst;
    logic          pc_valid;
    logic          pc_inc;
    logic          pc_load;
    wire  [N-1:0]  data;
    logic [N-1:0]  mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [N-1:0]  mem_rdata;
    logic [N-1:0]  ir;
    logic          ir_valid;
    logic          ir_ready;
    logic          jmp_req;
    logic [N-1:0]  jmp_addr;
    logic          jmp_ack;
    logic          halt;
    logic          err;

    fetch_ctrl #(
        .N (N)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pc_valid  (pc_valid),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .data      (data),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .jmp_req   (jmp_req),
        .jmp_addr  (jmp_addr),
        .jmp_ack   (jmp_ack),
        .halt      (halt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC block: drives the bus while pc_valid, loads/increments at the edge
    logic [7:0] pc;
    logic       pc_set;
    logic [7:0] pc_set_val;
    assign data = pc_valid ? pc : 8'bz;
    always @(posedge clk) begin
        if (pc_set)       pc <= pc_set_val;
        else if (pc_load) pc <= data;
        else if (pc_inc)  pc <= pc + 8'd1;
    end

    logic [7:0] mem [256];

    // Reference model: what the fetch unit is doing this cycle
    typedef enum {A_FREE, A_ASK, A_WAIT, A_SHOW, A_BRANCH} act_t;
    act_t       act;
    logic [7:0] exp_pc, exp_addr, exp_ir;

    // Stimulus plan for the next cycle
    logic       p_halt, p_ready, p_jump;
    logic [7:0] p_target;
    int         p_delay;

    int         wcnt, req_len, last_req_len, n_inc;
    logic [7:0] accepted [$];
    int         n_cmp, n_bad;

    task automatic chk1(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, got, want, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h at %0t", nm, got, want, $time);
        end
    endtask

    // One clock cycle: compare, apply inputs, compare pc_inc, advance model
    task automatic cycle();
        @(negedge clk);
        chk1("pc_valid", pc_valid, act == A_ASK);
        chk1("mem_req",  mem_req,  act == A_WAIT);
        chk1("ir_valid", ir_valid, act == A_SHOW);
        chk1("pc_load",  pc_load,  act == A_BRANCH);
        chk1("jmp_ack",  jmp_ack,  act == A_BRANCH);
        chk1("err",      err,      1'b0);
        chk8("mem_addr", mem_addr, exp_addr);
        chk8("ir",       ir,       exp_ir);
        chk8("pc",       pc,       exp_pc);
        chk1("bus_excl", pc_valid & pc_load, 1'b0);
        if (act == A_BRANCH) chk8("bus_data", data, jmp_addr);

        halt     = p_halt;
        ir_ready = p_ready;
        if (jmp_req && jmp_ack) begin
            jmp_req = 1'b0;
        end else if (!jmp_req && p_jump) begin
            jmp_req  = 1'b1;
            jmp_addr = p_target;
        end

        // Memory: ack after wcnt wait cycles, junk data when not acking
        mem_rdata = 8'($urandom);
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt    = p_delay;
            if (req_len != 0) last_req_len = req_len;
            req_len = 0;
        end else begin
            req_len++;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (wcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                wcnt--;
            end
        end
        if (ir_valid && ir_ready) accepted.push_back(ir);

        #1;
        chk1("pc_inc", pc_inc, (act == A_WAIT) && mem_ack);
        if (pc_inc) n_inc++;

        case (act)
            A_FREE: begin
                if (jmp_req)    act = A_BRANCH;
                else if (!halt) act = A_ASK;
            end
            A_ASK: begin
                exp_addr = exp_pc;
                act      = A_WAIT;
            end
            A_WAIT: begin
                if (mem_ack) begin
                    exp_ir = mem[exp_addr];
                    exp_pc = exp_pc + 8'd1;
                    act    = A_SHOW;
                end
            end
            A_SHOW: begin
                if (jmp_req)       act = A_BRANCH;
                else if (ir_ready) act = halt ? A_FREE : A_ASK;
            end
            A_BRANCH: begin
                exp_pc = jmp_addr;
                act    = halt ? A_FREE : A_ASK;
            end
            default: act = A_FREE;
        endcase
    endtask

    // Assert reset between edges, check outputs clear at once, release after an edge
    task automatic do_reset(input logic set_pc, input logic [7:0] start_pc);
        nrst    = 1'b0;
        mem_ack = 1'b0;
        jmp_req = 1'b0;
        #1;
        chk1("rst_mem_req",  mem_req,  1'b0);
        chk1("rst_ir_valid", ir_valid, 1'b0);
        chk1("rst_pc_valid", pc_valid, 1'b0);
        chk1("rst_pc_load",  pc_load,  1'b0);
        chk1("rst_pc_inc",   pc_inc,   1'b0);
        chk1("rst_jmp_ack",  jmp_ack,  1'b0);
        chk1("rst_err",      err,      1'b0);
        chk8("rst_ir",       ir,       8'h00);
        chk8("rst_mem_addr", mem_addr, 8'h00);
        pc_set_val = start_pc;
        pc_set     = set_pc;
        @(posedge clk);
        #1;
        pc_set = 1'b0;
        nrst   = 1'b1;
        act      = A_FREE;
        exp_pc   = pc;
        exp_addr = 8'h00;
        exp_ir   = 8'h00;
        req_len  = 0;
        last_req_len = 0;
        n_inc    = 0;
        accepted.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not end, n_cmp %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] pc_before;
        logic [7:0] m10;
        nrst = 1'b1; halt = 1'b1; ir_ready = 1'b0; jmp_req = 1'b0; jmp_addr = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00; pc_set = 1'b0; pc_set_val = 8'h00;
        p_halt = 1'b0; p_ready = 1'b0; p_jump = 1'b0; p_target = 8'h00; p_delay = 0;
        wcnt = 0; req_len = 0; last_req_len = 0; n_inc = 0; n_cmp = 0; n_bad = 0;
        act = A_FREE; exp_pc = 8'h00; exp_addr = 8'h00; exp_ir = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        #2;

        // Single fetch from 04, zero-wait memory
        mem[8'h04] = 8'hA5;
        do_reset(1'b1, 8'h04);
        repeat (4) cycle();
        chk8("t1_mem_addr", mem_addr, 8'h04);
        chk8("t1_ir",       ir,       8'hA5);
        chk1("t1_ir_valid", ir_valid, 1'b1);
        chk8("t1_pc",       pc,       8'h05);
        chk8("t1_inc_cnt",  8'(n_inc), 8'd1);

        // Back-to-back fetches 04..06
        mem[8'h04] = 8'h11; mem[8'h05] = 8'h22; mem[8'h06] = 8'h33;
        p_ready = 1'b1;
        do_reset(1'b1, 8'h04);
        repeat (9) cycle();
        p_halt = 1'b1;
        cycle();
        chk8("t2_count", 8'(accepted.size()), 8'd3);
        if (accepted.size() >= 3) begin
            chk8("t2_ir0", accepted[0], 8'h11);
            chk8("t2_ir1", accepted[1], 8'h22);
            chk8("t2_ir2", accepted[2], 8'h33);
        end
        chk8("t2_pc", pc, 8'h07);

        // Jump from HOLD with decoder stalled
        p_halt = 1'b0; p_ready = 1'b0;
        k = 0;
        while (!ir_valid && k < 10) begin
            cycle();
            k++;
        end
        chk1("t3_reach_hold", ir_valid, 1'b1);
        p_jump = 1'b1; p_target = 8'h40;
        cycle();
        p_jump = 1'b0;
        cycle();
        chk1("t3_pc_load",  pc_load,  1'b1);
        chk1("t3_jmp_ack",  jmp_ack,  1'b1);
        chk1("t3_ir_valid", ir_valid, 1'b0);
        chk1("t3_pc_inc",   pc_inc,   1'b0);
        chk8("t3_data",     data,     8'h40);
        cycle();
        cycle();
        chk8("t3_mem_addr", mem_addr, 8'h40);

        // Five wait states, then halt while holding
        p_delay = 5;
        m10 = mem[8'h10];
        do_reset(1'b1, 8'h10);
        repeat (12) cycle();
        chk8("t4_req_len",  8'(last_req_len), 8'd6);
        chk8("t4_ir",       ir,       m10);
        chk1("t4_ir_valid", ir_valid, 1'b1);
        p_halt = 1'b1;
        cycle();
        p_ready = 1'b1;
        repeat (5) cycle();
        chk1("t4_halt_pc_valid", pc_valid, 1'b0);
        chk1("t4_halt_mem_req",  mem_req,  1'b0);

        // Reset in the middle of a memory read
        p_halt = 1'b0; p_ready = 1'b0; p_delay = 10;
        do_reset(1'b1, 8'h20);
        repeat (4) cycle();
        chk1("t5_in_mem", mem_req, 1'b1);
        pc_before = pc;
        do_reset(1'b0, 8'h00);
        chk8("t5_pc_kept", pc, pc_before);
        chk8("t5_pc_val",  pc, 8'h20);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            p_halt   = ($urandom_range(0, 7) == 0);
            p_ready  = 1'($urandom_range(0, 1));
            p_jump   = ($urandom_range(0, 9) == 0);
            p_target = 8'($urandom);
            p_delay  = $urandom_range(0, 4);
            if (i % 1000 == 999) do_reset(1'b0, 8'h00);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
